ascon_pad_loader: RTL



---
 rtl/ascon_pad_loader.sv | 114 +++++++++++
 1 files changed

// File: rtl/ascon_pad_loader.sv
// Pad-side input stage: synchronizes the byte-parallel host pads, packs bytes
// into 64-bit words and offers them to the ASCON core over valid/ready.
module ascon_pad_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BYTES  = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [13:0] pad_in,
  output logic [63:0] word_o,
  output logic [2:0]  word_sel_o,
  output logic        word_last_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [2:0]  status_o
);

  localparam int CW = $clog2(WORD_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                 state;
  logic [13:0]            sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] prime_q;
  logic [13:0]            pad_s;
  logic                   strobe_prev;
  logic                   abort_prev;
  logic                   strobe_armed;
  logic                   strobe_edge;
  logic                   abort_edge;
  logic [CW-1:0]          count;
  logic                   overrun;

  assign pad_s = sync_q[SYNC_STAGES-1];

  // A strobe already high when reset is released must fall before it can
  // count, so edges are only armed once a real (post-reset) low is seen.
  assign strobe_edge = pad_s[8] & ~strobe_prev & strobe_armed;
  assign abort_edge  = pad_s[13] & ~abort_prev;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prime_q      <= '0;
      strobe_prev  <= 1'b0;
      abort_prev   <= 1'b0;
      strobe_armed <= 1'b0;
    end else begin
      sync_q[0] <= pad_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prime_q     <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      strobe_prev <= pad_s[8];
      abort_prev  <= pad_s[13];
      if (prime_q[SYNC_STAGES-1] && !pad_s[8]) strobe_armed <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      word_o      <= '0;
      word_sel_o  <= '0;
      word_last_o <= 1'b0;
      count       <= '0;
      overrun     <= 1'b0;
    end else if (abort_edge) begin
      state   <= IDLE;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (strobe_edge) begin
            word_o     <= {word_o[55:0], pad_s[7:0]};
            word_sel_o <= pad_s[11:9];
            count      <= CW'(1);
            if (WORD_BYTES == 1) begin
              word_last_o <= pad_s[12];
              state       <= HOLD;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (strobe_edge) begin
            word_o <= {word_o[55:0], pad_s[7:0]};
            count  <= count + 1'b1;
            if (count == CW'(WORD_BYTES - 1)) begin
              word_last_o <= pad_s[12];
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (word_ready_i) begin
            state <= IDLE;
            count <= '0;
          end
          if (strobe_edge) overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign word_valid_o = (state == HOLD);
  assign status_o     = {overrun, word_valid_o, (state != HOLD)};

endmodule
